// File: rtl/biriscv_imem_arb_pkg.sv
// Shared types for the instruction-memory arbiter: requester IDs, arbiter states and
// the per-requester response bundle.
package biriscv_imem_arb_pkg;

    typedef enum logic {
        REQ_F = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    typedef enum logic [1:0] {
        StIdle,
        StLockF,
        StLockD
    } arb_state_e;

    typedef struct packed {
        logic        valid;
        logic [63:0] inst;
        logic        error;
        logic        page_fault;
    } resp_t;

    // Status bits are only meaningful for the owner of the response.
    function automatic resp_t mk_resp(input logic sel, input logic [63:0] inst,
                                      input logic err, input logic pf);
        resp_t r;
        r.valid      = sel;
        r.inst       = inst;
        r.error      = sel & err;
        r.page_fault = sel & pf;
        return r;
    endfunction

endpackage

// File: rtl/biriscv_imem_arb_if.sv
// Bundle of fetch, debug and icache signals around the instruction-memory arbiter.
// master: arbiter side; slave: surrounding fetch/debug/icache side.
interface biriscv_imem_arb_if;

    logic        f_rd_i;
    logic [31:0] f_pc_i;
    logic [1:0]  f_priv_i;
    logic        f_flush_i;
    logic        f_invalidate_i;
    logic        f_accept_o;
    logic        f_valid_o;
    logic [63:0] f_inst_o;
    logic        f_error_o;
    logic        f_page_fault_o;

    logic        d_rd_i;
    logic [31:0] d_pc_i;
    logic [1:0]  d_priv_i;
    logic        d_accept_o;
    logic        d_valid_o;
    logic [63:0] d_inst_o;
    logic        d_error_o;
    logic        d_page_fault_o;

    logic        icache_rd_o;
    logic [31:0] icache_pc_o;
    logic [1:0]  icache_priv_o;
    logic        icache_flush_o;
    logic        icache_invalidate_o;
    logic        icache_accept_i;
    logic        icache_valid_i;
    logic [63:0] icache_inst_i;
    logic        icache_error_i;
    logic        icache_page_fault_i;

    modport master (
        input  f_rd_i, f_pc_i, f_priv_i, f_flush_i, f_invalidate_i,
        output f_accept_o, f_valid_o, f_inst_o, f_error_o, f_page_fault_o,
        input  d_rd_i, d_pc_i, d_priv_i,
        output d_accept_o, d_valid_o, d_inst_o, d_error_o, d_page_fault_o,
        output icache_rd_o, icache_pc_o, icache_priv_o, icache_flush_o, icache_invalidate_o,
        input  icache_accept_i, icache_valid_i, icache_inst_i, icache_error_i,
        input  icache_page_fault_i
    );

    modport slave (
        output f_rd_i, f_pc_i, f_priv_i, f_flush_i, f_invalidate_i,
        input  f_accept_o, f_valid_o, f_inst_o, f_error_o, f_page_fault_o,
        output d_rd_i, d_pc_i, d_priv_i,
        input  d_accept_o, d_valid_o, d_inst_o, d_error_o, d_page_fault_o,
        input  icache_rd_o, icache_pc_o, icache_priv_o, icache_flush_o, icache_invalidate_o,
        output icache_accept_i, icache_valid_i, icache_inst_i, icache_error_i,
        output icache_page_fault_i
    );

endinterface

// File: rtl/biriscv_imem_arb_idfifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered icache requests.
// A push is taken while full only if a pop happens in the same cycle.
module biriscv_imem_arb_idfifo
    import biriscv_imem_arb_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned PtrW  = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  req_id_e       push_id_i,
    input  logic          pop_i,
    output req_id_e       head_o,
    output logic [PtrW:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    req_id_e         mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            do_push, do_pop;

    // Wrap explicitly so a depth below 2**PtrW never indexes past the array.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/biriscv_imem_arb.sv
// Arbitrates fetch (F) and debug (D) reads onto one icache port, routes in-order
// responses back by owner and sequences flush/invalidate once the port drains.
// Optional D anti-starvation priority: define BIRISCV_IMEM_ARB_STARVE_EN.
module biriscv_imem_arb
    import biriscv_imem_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING   = 2,
    parameter int unsigned MAX_OUTSTANDING_W = 1,
    parameter int unsigned STARVE_LIMIT      = 8
) (
    input logic                clk_i,
    input logic                rst_i,
    biriscv_imem_arb_if.master bus
);

    if (MAX_OUTSTANDING == 0 || MAX_OUTSTANDING > (1 << MAX_OUTSTANDING_W)) begin : g_bad_depth
        $error("MAX_OUTSTANDING does not fit in MAX_OUTSTANDING_W bits");
    end
    if (STARVE_LIMIT == 0) begin : g_bad_starve
        $error("STARVE_LIMIT must be at least 1");
    end

    arb_state_e               state_q, state_d;
    logic                     gnt_f, gnt_d;
    logic                     can_grant, d_prio;
    logic                     f_acc, d_acc, pop;
    logic                     fire;
    logic                     flush_pend_q, flush_pend_d;
    logic                     inv_pend_q, inv_pend_d;
    req_id_e                  head_id;
    logic [MAX_OUTSTANDING_W:0] count;
    logic                     full, empty;
    resp_t                    resp_f, resp_d;

    // New grants stop as soon as a flush/invalidate is requested, not a cycle later.
    assign can_grant = ~full & ~flush_pend_q & ~inv_pend_q & ~bus.f_flush_i &
                       ~bus.f_invalidate_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next state: hold the grant while the icache has not taken it.
    always_comb begin
        state_d = StIdle;
        if (gnt_f && !bus.icache_accept_i)      state_d = StLockF;
        else if (gnt_d && !bus.icache_accept_i) state_d = StLockD;
    end

    // Outputs: grant selection and request mux
    always_comb begin
        gnt_f = 1'b0;
        gnt_d = 1'b0;
        unique case (state_q)
            StLockF: gnt_f = 1'b1;
            StLockD: gnt_d = 1'b1;
            StIdle: begin
                if (can_grant) begin
                    if (d_prio && bus.d_rd_i) gnt_d = 1'b1;
                    else if (bus.f_rd_i)      gnt_f = 1'b1;
                    else                      gnt_d = bus.d_rd_i;
                end
            end
            default: ;
        endcase
        if (rst_i) begin
            gnt_f = 1'b0;
            gnt_d = 1'b0;
        end
        bus.icache_rd_o   = gnt_f | gnt_d;
        bus.icache_pc_o   = gnt_d ? bus.d_pc_i : bus.f_pc_i;
        bus.icache_priv_o = gnt_d ? bus.d_priv_i : bus.f_priv_i;
    end

    assign f_acc          = gnt_f & bus.icache_accept_i;
    assign d_acc          = gnt_d & bus.icache_accept_i;
    assign bus.f_accept_o = f_acc;
    assign bus.d_accept_o = d_acc;

    biriscv_imem_arb_idfifo #(
        .Depth (MAX_OUTSTANDING),
        .PtrW  (MAX_OUTSTANDING_W)
    ) u_idfifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (f_acc | d_acc),
        .push_id_i (d_acc ? REQ_D : REQ_F),
        .pop_i     (pop),
        .head_o    (head_id),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty)
    );

    // Responses with nothing outstanding are stale and dropped.
    assign pop    = bus.icache_valid_i & ~empty & ~rst_i;
    assign resp_f = mk_resp(pop && (head_id == REQ_F), bus.icache_inst_i,
                            bus.icache_error_i, bus.icache_page_fault_i);
    assign resp_d = mk_resp(pop && (head_id == REQ_D), bus.icache_inst_i,
                            bus.icache_error_i, bus.icache_page_fault_i);

    assign bus.f_valid_o      = resp_f.valid;
    assign bus.f_inst_o       = resp_f.inst;
    assign bus.f_error_o      = resp_f.error;
    assign bus.f_page_fault_o = resp_f.page_fault;
    assign bus.d_valid_o      = resp_d.valid;
    assign bus.d_inst_o       = resp_d.inst;
    assign bus.d_error_o      = resp_d.error;
    assign bus.d_page_fault_o = resp_d.page_fault;

    // Flush/invalidate fire once nothing is outstanding and no handshake is open.
    assign fire         = ~rst_i & (count == '0) & (state_q == StIdle);
    assign flush_pend_d = bus.f_flush_i | (flush_pend_q & ~fire);
    assign inv_pend_d   = bus.f_invalidate_i | (inv_pend_q & ~fire);

    assign bus.icache_flush_o      = flush_pend_q & fire;
    assign bus.icache_invalidate_o = inv_pend_q & fire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_pend_q <= 1'b0;
            inv_pend_q   <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
            inv_pend_q   <= inv_pend_d;
        end
    end

`ifdef BIRISCV_IMEM_ARB_STARVE_EN
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    logic [StarveW-1:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (!bus.d_rd_i || d_acc) begin
            starve_d = '0;
        end else if (!gnt_d && (starve_q != StarveW'(STARVE_LIMIT))) begin
            starve_d = starve_q + StarveW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) starve_q <= '0;
        else       starve_q <= starve_d;
    end

    assign d_prio = (starve_q == StarveW'(STARVE_LIMIT));
`else
    assign d_prio = 1'b0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i && bus.icache_valid_i) begin
            assert (!empty)
            else $warning("icache response dropped: no request outstanding");
        end
    end
`endif

endmodule

// File: tb/tb_biriscv_imem_arb.sv
// Self-checking bench for biriscv_imem_arb: a queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_biriscv_imem_arb;

    localparam int MaxOut      = 2;
    localparam int StarveLimit = 8;
`ifdef BIRISCV_IMEM_ARB_STARVE_EN
    localparam bit StarveOn = 1'b1;
`else
    localparam bit StarveOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    biriscv_imem_arb_if bus ();

    biriscv_imem_arb #(
        .MAX_OUTSTANDING   (MaxOut),
        .MAX_OUTSTANDING_W (1),
        .STARVE_LIMIT      (StarveLimit)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Reference state: owners of outstanding requests in order, open handshake owner
    // (-1 none, 0 F, 1 D), pending flush/invalidate, D wait count.
    int mq[$];
    int m_lock;
    bit m_pf, m_pi;
    int m_starve;
    bit m_f_acc, m_d_acc;
    int n_vec, n_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle();
        int own, head;
        bit acc, fire, rv, starved;
        m_f_acc = 1'b0;
        m_d_acc = 1'b0;
        if (rst) begin
            chk("rst_icache_rd", bus.icache_rd_o, 0);
            chk("rst_f_accept", bus.f_accept_o, 0);
            chk("rst_d_accept", bus.d_accept_o, 0);
            chk("rst_f_valid", bus.f_valid_o, 0);
            chk("rst_d_valid", bus.d_valid_o, 0);
            chk("rst_flush", bus.icache_flush_o, 0);
            chk("rst_inval", bus.icache_invalidate_o, 0);
            mq.delete();
            m_lock = -1;
            m_pf = 1'b0;
            m_pi = 1'b0;
            m_starve = 0;
            return;
        end
        starved = StarveOn && (m_starve >= StarveLimit);
        own = -1;
        if (m_lock >= 0) begin
            own = m_lock;
        end else if (mq.size() < MaxOut && !m_pf && !m_pi && !bus.f_flush_i &&
                     !bus.f_invalidate_i) begin
            if (starved && bus.d_rd_i) own = 1;
            else if (bus.f_rd_i)      own = 0;
            else if (bus.d_rd_i)      own = 1;
        end
        acc = (own >= 0) && bus.icache_accept_i;
        chk("icache_rd", bus.icache_rd_o, own >= 0);
        if (own == 0) begin
            chk("icache_pc_f", bus.icache_pc_o, bus.f_pc_i);
            chk("icache_priv_f", bus.icache_priv_o, bus.f_priv_i);
        end else if (own == 1) begin
            chk("icache_pc_d", bus.icache_pc_o, bus.d_pc_i);
            chk("icache_priv_d", bus.icache_priv_o, bus.d_priv_i);
        end
        chk("f_accept", bus.f_accept_o, acc && own == 0);
        chk("d_accept", bus.d_accept_o, acc && own == 1);
        fire = (mq.size() == 0) && (m_lock < 0);
        chk("icache_flush", bus.icache_flush_o, m_pf && fire);
        chk("icache_inval", bus.icache_invalidate_o, m_pi && fire);
        rv = bus.icache_valid_i && (mq.size() > 0);
        head = rv ? mq[0] : -1;
        chk("f_valid", bus.f_valid_o, head == 0);
        chk("d_valid", bus.d_valid_o, head == 1);
        if (head == 0) chk("f_inst", bus.f_inst_o, bus.icache_inst_i);
        if (head == 1) chk("d_inst", bus.d_inst_o, bus.icache_inst_i);
        chk("f_error", bus.f_error_o, head == 0 && bus.icache_error_i);
        chk("d_error", bus.d_error_o, head == 1 && bus.icache_error_i);
        chk("f_pf", bus.f_page_fault_o, head == 0 && bus.icache_page_fault_i);
        chk("d_pf", bus.d_page_fault_o, head == 1 && bus.icache_page_fault_i);
        if (rv) void'(mq.pop_front());
        if (acc) mq.push_back(own);
        m_lock = (own >= 0 && !acc) ? own : -1;
        m_pf = bus.f_flush_i || (m_pf && !fire);
        m_pi = bus.f_invalidate_i || (m_pi && !fire);
        if (!bus.d_rd_i || (acc && own == 1)) m_starve = 0;
        else if (own != 1 && m_starve < StarveLimit) m_starve++;
        m_f_acc = acc && own == 0;
        m_d_acc = acc && own == 1;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.f_rd_i = 0; bus.f_pc_i = 0; bus.f_priv_i = 0;
        bus.f_flush_i = 0; bus.f_invalidate_i = 0;
        bus.d_rd_i = 0; bus.d_pc_i = 0; bus.d_priv_i = 0;
        bus.icache_accept_i = 0; bus.icache_valid_i = 0; bus.icache_inst_i = 0;
        bus.icache_error_i = 0; bus.icache_page_fault_i = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && mq.size() > 0; i++) begin
            bus.icache_valid_i = 1;
            bus.icache_inst_i = {$urandom, $urandom};
            step();
        end
        bus.icache_valid_i = 0;
        chk("drained", mq.size(), 0);
    endtask

    initial begin
        int first, nflush;
        n_vec = 0;
        n_err = 0;
        m_lock = -1;
        idle();
        rst = 1;
        step();
        step();
        rst = 0;

        // 1: F beats D, responses route in order
        bus.f_rd_i = 1; bus.f_pc_i = 32'h1000; bus.d_rd_i = 1; bus.d_pc_i = 32'h2000;
        bus.icache_accept_i = 1;
        #1;
        chk("t1_pc_f", bus.icache_pc_o, 32'h1000);
        chk("t1_f_acc", bus.f_accept_o, 1);
        step();
        bus.f_rd_i = 0;
        #1;
        chk("t1_pc_d", bus.icache_pc_o, 32'h2000);
        chk("t1_d_acc", bus.d_accept_o, 1);
        step();
        bus.d_rd_i = 0; bus.icache_accept_i = 0;
        bus.icache_valid_i = 1; bus.icache_inst_i = 64'h1111;
        #1;
        chk("t1_rsp1_f", bus.f_valid_o, 1);
        chk("t1_rsp1_d", bus.d_valid_o, 0);
        chk("t1_rsp1_inst", bus.f_inst_o, 64'h1111);
        step();
        bus.icache_inst_i = 64'h2222;
        #1;
        chk("t1_rsp2_d", bus.d_valid_o, 1);
        chk("t1_rsp2_f", bus.f_valid_o, 0);
        step();
        bus.icache_valid_i = 0;
        chk("t1_model_empty", mq.size(), 0);

        // 2: locked D handshake is not pre-empted by F
        bus.d_rd_i = 1; bus.d_pc_i = 32'h2000; bus.icache_accept_i = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                bus.f_rd_i = 1; bus.f_pc_i = 32'h1000;
            end
            #1;
            chk("t2_locked_pc", bus.icache_pc_o, 32'h2000);
            chk("t2_no_accept", bus.f_accept_o | bus.d_accept_o, 0);
            step();
        end
        bus.icache_accept_i = 1;
        #1;
        chk("t2_d_acc", bus.d_accept_o, 1);
        chk("t2_pc_d", bus.icache_pc_o, 32'h2000);
        step();
        bus.d_rd_i = 0;
        #1;
        chk("t2_f_acc", bus.f_accept_o, 1);
        chk("t2_pc_f", bus.icache_pc_o, 32'h1000);
        step();
        bus.f_rd_i = 0;
        drain();

        // 3: flush waits for two outstanding responses, pulses once, grants resume
        bus.f_rd_i = 1; bus.f_pc_i = 32'h3000; bus.icache_accept_i = 1;
        step();
        bus.f_rd_i = 0; bus.d_rd_i = 1; bus.d_pc_i = 32'h4000;
        step();
        bus.d_rd_i = 0;
        bus.f_rd_i = 1; bus.f_pc_i = 32'h5000; bus.f_flush_i = 1;
        bus.icache_valid_i = 1;
        nflush = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.icache_flush_o) nflush++;
            chk("t3_f_acc", bus.f_accept_o, c == 3);
            step();
            bus.f_flush_i = 0;
            if (c == 1) bus.icache_valid_i = 0;
        end
        bus.f_rd_i = 0;
        chk("t3_flush_pulses", nflush, 1);
        drain();

        // 4: error response owned by D
        bus.d_rd_i = 1; bus.d_pc_i = 32'h7000;
        step();
        bus.d_rd_i = 0;
        bus.icache_valid_i = 1; bus.icache_error_i = 1;
        #1;
        chk("t4_d_error", bus.d_error_o, 1);
        chk("t4_d_valid", bus.d_valid_o, 1);
        chk("t4_f_valid", bus.f_valid_o, 0);
        chk("t4_f_error", bus.f_error_o, 0);
        step();
        bus.icache_valid_i = 0; bus.icache_error_i = 0;

        // 6: reset with two outstanding, then a stale response
        bus.f_rd_i = 1; bus.f_pc_i = 32'h8000;
        step();
        bus.f_rd_i = 0; bus.d_rd_i = 1; bus.d_pc_i = 32'h8800;
        step();
        bus.d_rd_i = 0; bus.f_rd_i = 1; bus.f_pc_i = 32'h8100;
        rst = 1;
        #1;
        chk("t6_rst_no_acc", bus.f_accept_o, 0);
        chk("t6_rst_no_rd", bus.icache_rd_o, 0);
        step();
        rst = 0; bus.f_rd_i = 0; bus.icache_valid_i = 1;
        #1;
        chk("t6_stale_f_valid", bus.f_valid_o, 0);
        chk("t6_stale_d_valid", bus.d_valid_o, 0);
        step();
        bus.icache_valid_i = 0;

        // 5: F requests back-to-back while D waits
        first = -1;
        bus.d_rd_i = 1; bus.d_pc_i = 32'h6000;
        bus.f_rd_i = 1; bus.f_pc_i = 32'h9000; bus.icache_accept_i = 1;
        for (int c = 0; c < 20; c++) begin
            bus.icache_valid_i = mq.size() > 0;
            #1;
            if (first < 0 && bus.d_accept_o) first = c;
            step();
            if (m_d_acc) bus.d_rd_i = 0;
            if (m_f_acc) bus.f_pc_i = bus.f_pc_i + 32'd4;
        end
        chk("t5_d_grant_cycle", first, StarveOn ? 8 : -1);
        bus.f_rd_i = 0; bus.d_rd_i = 0;
        drain();

        // Randomized traffic obeying the hold-until-accept contract
        for (int n = 0; n < 3000; n++) begin
            if (!bus.f_rd_i && $urandom_range(0, 2) == 0) begin
                bus.f_rd_i = 1; bus.f_pc_i = $urandom & 32'hFFFF_FFFC; bus.f_priv_i = 2'($urandom);
            end
            if (!bus.d_rd_i && $urandom_range(0, 3) == 0) begin
                bus.d_rd_i = 1; bus.d_pc_i = $urandom & 32'hFFFF_FFFC; bus.d_priv_i = 2'($urandom);
            end
            bus.icache_accept_i = ($urandom_range(0, 3) != 0);
            bus.icache_valid_i = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.icache_inst_i = {$urandom, $urandom};
            bus.icache_error_i = ($urandom_range(0, 7) == 0);
            bus.icache_page_fault_i = ($urandom_range(0, 7) == 0);
            bus.f_flush_i = ($urandom_range(0, 49) == 0);
            bus.f_invalidate_i = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
            if (m_f_acc) bus.f_rd_i = 0;
            if (m_d_acc) bus.d_rd_i = 0;
            bus.f_flush_i = 0;
            bus.f_invalidate_i = 0;
            rst = 0;
        end

        idle();
        rst = 1;
        step();
        rst = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/biriscv_imem_arb.md
Name: biriscv_imem_arb

Overview:
- Shares the single instruction-cache request port between two requesters: requester F (fetch unit) and requester D (debug/trace instruction reader).
- Sits between the frontend fetch stage and the icache.
- Arbitrates requests and records the owner of each accepted request in an in-order ID FIFO.
- Routes each in-order icache response back to its owner, and sequences flush/invalidate after outstanding requests drain.

Parameters:
MAX_OUTSTANDING, 2, max accepted-but-unanswered icache requests (power of two, >=1)
MAX_OUTSTANDING_W, 1, log2(MAX_OUTSTANDING), minimum 1
STARVE_LIMIT, 8, cycles D may wait before it gets priority (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
f_rd_i  in  1  fetch read request
f_pc_i  in  32  fetch address
f_priv_i  in  2  fetch privilege
f_flush_i  in  1  fetch flush request (1-cycle pulse)
f_invalidate_i  in  1  fetch invalidate request (1-cycle pulse)
f_accept_o  out  1  fetch request accepted
f_valid_o  out  1  response valid for fetch
f_inst_o  out  64  response data for fetch
f_error_o  out  1  bus error for fetch
f_page_fault_o  out  1  page fault for fetch
d_rd_i  in  1  debug read request
d_pc_i  in  32  debug address
d_priv_i  in  2  debug privilege
d_accept_o  out  1  debug request accepted
d_valid_o  out  1  response valid for debug
d_inst_o  out  64  response data for debug
d_error_o  out  1  bus error for debug
d_page_fault_o  out  1  page fault for debug
icache_rd_o  out  1  icache request
icache_pc_o  out  32  icache address
icache_priv_o  out  2  icache privilege
icache_flush_o  out  1  icache flush pulse
icache_invalidate_o  out  1  icache invalidate pulse
icache_accept_i  in  1  icache accepted request
icache_valid_i  in  1  icache response valid
icache_inst_i  in  64  icache response data
icache_error_i  in  1  icache bus error
icache_page_fault_i  in  1  icache page fault

Behaviour:
- Single clock clk_i; synchronous active-high reset rst_i.
- Reset state: ID FIFO empty, count=0, lock clear, flush/invalidate pending clear, starve counter 0.
- Reset values of outputs: all *_valid_o, *_accept_o, icache_rd_o, icache_flush_o and icache_invalidate_o are 0.
- Requester contract: rd, pc and priv are held stable until accept.
- Grant rules:
  - Grant is allowed only when count<MAX_OUTSTANDING and no flush/invalidate is pending.
  - Default priority is F over D.
  - The request mux is combinational; icache_rd_o/pc/priv follow the granted requester in the same cycle.
  - Lock: if the granted rd is not accepted by icache_accept_i, the grant is registered and held until acceptance. No switching mid-handshake, even if F asserts.
- Accept: x_accept_o = grant_x & icache_accept_i. On accept, push the owner ID (0=F, 1=D) into the FIFO.
- Response:
  - When icache_valid_i is high, pop the FIFO head and drive that owner's valid/inst/error/page_fault in the same cycle (zero latency).
  - The other owner's valid stays 0; inst is passed to both.
- Simultaneous push and pop: count unchanged. Count never exceeds MAX_OUTSTANDING (enforced by the grant gate).
- icache_valid_i with count=0 (e.g. after reset mid-operation): the response is dropped, no valid driven, with a simulation-only assertion.
- Flush/invalidate:
  - f_flush_i / f_invalidate_i set the pending bits.
  - Once count==0 and no lock is active, icache_flush_o / icache_invalidate_o pulse for exactly one cycle, then the pending bits clear.
  - Both may be issued in the same cycle. If count is already 0 the pulse comes 1 cycle after the request (registered).
- Lock on reset: a reset asserted during a locked handshake drops the request; no accept is generated in the reset cycle.

Optional Feature:
- Macro: BIRISCV_IMEM_ARB_STARVE_EN.
- With the macro defined:
  - The starve counter increments each cycle that d_rd_i is high and D is not granted; it saturates at STARVE_LIMIT.
  - At STARVE_LIMIT, D gets priority on the next arbitration.
  - The counter clears when D is accepted or d_rd_i is low.
- Without the macro: strict F priority; D can starve indefinitely; no counter logic is present.

Decomposition:
- Package biriscv_imem_arb_pkg holds:
  - the requester ID typedef (REQ_F=0, REQ_D=1);
  - the response bundle struct (valid, inst[63:0], error, page_fault).
- Sub-module biriscv_imem_arb_idfifo: synchronous FIFO of 1-bit IDs, depth MAX_OUTSTANDING, with push/pop/count/full/empty.
  - Simultaneous push/pop is supported when full.

Test Plan:
1. F and D both request at 0x1000 / 0x2000, icache_accept_i=1, MAX_OUTSTANDING=2 → F accepted first, then D. Two valid responses route to F then D; count returns to 0.
2. D requests, icache_accept_i=0 for 3 cycles, F asserts in cycle 2 → icache_pc_o stays 0x2000 (locked) until accept; F is granted afterwards.
3. Two requests accepted, f_flush_i pulsed → no new accepts, flush held until both responses return; icache_flush_o high for exactly 1 cycle, then grants resume.
4. Response with icache_error_i=1 while FIFO head=D → d_error_o=1, d_valid_o=1, f_valid_o=0.
5. F requests continuously, D waits, BIRISCV_IMEM_ARB_STARVE_EN defined → D is granted after 8 wait cycles. Without the macro, D is never granted.
6. rst_i asserted with count=2 → count=0 next cycle; a late icache_valid_i produces no f_valid_o/d_valid_o.
